// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N-input registered stream mux, round-robin or fixed select; define STREAM_MUX_LAST_LOCK_EN to hold the grant until the end of a packet
module stream_mux_rr #(
    parameter int N  = 4,
    parameter int W  = 8,
    parameter int SW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            mode,
    input  logic [SW-1:0]   sel,
    input  logic [N-1:0]    in_valid,
    input  logic [N*W-1:0]  in_data,
    input  logic [N-1:0]    in_last,
    output logic [N-1:0]    in_ready,
    output logic            out_valid,
    output logic [W-1:0]    out_data,
    output logic [SW-1:0]   out_sel,
    output logic            out_last,
    input  logic            out_ready
);
    logic [SW-1:0] ptr;
    logic [SW-1:0] gidx;
    logic [SW-1:0] cand;
    logic [SW-1:0] ptr_nxt;
    logic          found;
    logic          free;
    logic          xfer;
`ifdef STREAM_MUX_LAST_LOCK_EN
    logic          lock;
    logic [SW-1:0] lock_ch;
`endif
    always_comb begin
        gidx  = '0;
        cand  = '0;
        found = 1'b0;
        if (mode) begin
            if (int'(sel) < N && in_valid[sel]) begin
                gidx  = sel;
                found = 1'b1;
            end
        end
`ifdef STREAM_MUX_LAST_LOCK_EN
        else if (lock) begin
            gidx  = lock_ch;
            found = in_valid[lock_ch];
        end
`endif
        else begin
            for (int k = 0; k < N; k++) begin
                cand = SW'((int'(ptr) + k) % N);
                if (!found && in_valid[cand]) begin
                    gidx  = cand;
                    found = 1'b1;
                end
            end
        end
    end
    assign free     = !out_valid || out_ready;
    assign xfer     = found && free;
    assign in_ready = {{(N-1){1'b0}}, xfer} << gidx;
    assign ptr_nxt  = (gidx == SW'(N-1)) ? '0 : gidx + 1'b1;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            out_last  <= 1'b0;
            ptr       <= '0;
`ifdef STREAM_MUX_LAST_LOCK_EN
            lock      <= 1'b0;
            lock_ch   <= '0;
`endif
        end else begin
            if (free)
                out_valid <= xfer;
            if (xfer) begin
                out_data <= in_data[gidx*W +: W];
                out_sel  <= gidx;
                out_last <= in_last[gidx];
                if (!mode) begin
`ifdef STREAM_MUX_LAST_LOCK_EN
                    lock    <= !in_last[gidx];
                    lock_ch <= gidx;
                    if (in_last[gidx])
                        ptr <= ptr_nxt;
`else
                    ptr <= ptr_nxt;
`endif
                end
            end
        end
    end
endmodule
